// File: rtl/io_timer_if.sv
// Strobe-style VC16 I/O register bus, as seen by one peripheral slot.
interface io_timer_if;
    logic [3:0]  io_addr;
    logic        io_write;
    logic        io_read;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    modport master (
        output io_addr,
        output io_write,
        output io_read,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_addr,
        input  io_write,
        input  io_read,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_timer.sv
// io_timer: 16-bit timer for VC16 I/O slot 3. It has a prescaler, an up-counter,
// a compare match with optional auto-reload or one-shot stop, and overflow
// detection. The level interrupt goes to the intr block.
module io_timer #(
    parameter int CW = 16,
    parameter int PW = 8
) (
    input  logic       clk,
    input  logic       reset,
    io_timer_if.slave  bus,
    output logic       interrupt
);

    localparam logic [3:0] REG_COUNT   = 4'd0;
    localparam logic [3:0] REG_COMPARE = 4'd1;
    localparam logic [3:0] REG_CTRL    = 4'd2;
    localparam logic [3:0] REG_PRE     = 4'd3;
    localparam logic [3:0] REG_STATUS  = 4'd4;

    logic [CW-1:0] count;
    logic [CW-1:0] compare;
    logic          en;
    logic          reload;
    logic          ie;
    logic          oneshot;
    logic [PW-1:0] pre;
    logic [PW-1:0] pcnt;
    logic          match;
    logic          ovf;

    logic wr_count, wr_compare, wr_ctrl, wr_pre, wr_status;
    logic tick, hit, set_ovf;

    assign wr_count   = bus.io_write && (bus.io_addr == REG_COUNT);
    assign wr_compare = bus.io_write && (bus.io_addr == REG_COMPARE);
    assign wr_ctrl    = bus.io_write && (bus.io_addr == REG_CTRL);
    assign wr_pre     = bus.io_write && (bus.io_addr == REG_PRE);
    assign wr_status  = bus.io_write && (bus.io_addr == REG_STATUS);

    // Match and overflow are judged on the count value before any same-cycle write.
    assign tick    = en && (pcnt == pre);
    assign hit     = tick && (count == compare);
    assign set_ovf = tick && (count == {CW{1'b1}}) && !(hit && reload);

    // Prescaler: a PRE write restarts the divider; so does a COUNT write.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            pcnt <= '0;
        end else if (wr_pre || wr_count || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Counter: a software write beats the tick; the natural +1 wraps at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.io_wdata[CW-1:0];
        end else if (tick) begin
            count <= (hit && reload) ? '0 : count + CW'(1);
        end
    end

    // Configuration registers: a CTRL write overrides the one-shot auto-clear of EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= '0;
            pre     <= '0;
            en      <= 1'b0;
            reload  <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
        end else begin
            if (wr_compare) compare <= bus.io_wdata[CW-1:0];
            if (wr_pre)     pre     <= bus.io_wdata[PW-1:0];
            if (wr_ctrl) begin
                en      <= bus.io_wdata[0];
                reload  <= bus.io_wdata[1];
                ie      <= bus.io_wdata[2];
                oneshot <= bus.io_wdata[3];
            end else if (hit && oneshot) begin
                en <= 1'b0;
            end
        end
    end

    // Sticky status bits: write-1-to-clear, a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            match <= (match && !(wr_status && bus.io_wdata[0])) || hit;
            ovf   <= (ovf   && !(wr_status && bus.io_wdata[1])) || set_ovf;
        end
    end

    // Interrupt is a pure AND/OR of flop outputs, so no bus activity can glitch it.
    assign interrupt = ie && (match || ovf);

    // Read mux: combinational from the address, no side effects, unused bits 0.
    always_comb begin
        // NOTE: default first so every path assigns io_rdata and no latch is inferred.
        bus.io_rdata = '0;
        case (bus.io_addr)
            REG_COUNT:   bus.io_rdata = 16'(count);
            REG_COMPARE: bus.io_rdata = 16'(compare);
            REG_CTRL:    bus.io_rdata = {12'h000, oneshot, ie, reload, en};
            REG_PRE:     bus.io_rdata = 16'(pre);
            REG_STATUS:  bus.io_rdata = {14'h0000, ovf, match};
            default:     bus.io_rdata = '0;
        endcase
    end

endmodule
